// File: rtl/uart_apb_cmd_master.sv
// UART-byte-driven APB initiator: parses 'W' addr data / 'R' addr commands,
// runs one APB transfer and returns an ACK, NAK or read-data byte.
module uart_apb_cmd_master #(
  parameter int unsigned ADDR_WIDTH     = 5,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [7:0]  ACK_BYTE       = 8'h06,
  parameter logic [7:0]  NAK_BYTE       = 8'h15
) (
  input  logic                  PCLK,
  input  logic                  PRESETN,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [7:0]            PWDATA,
  input  logic [7:0]            PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR,
  output logic                  busy,
  output logic                  overrun
);

  localparam logic [7:0]  CmdWrite     = 8'h57;
  localparam logic [7:0]  CmdRead      = 8'h52;
  localparam logic [16:0] TimeoutLimit = 17'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    StIdle,
    StGetAddr,
    StGetData,
    StSetup,
    StAccess,
    StResp
  } state_e;

  state_e                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_paddr, w_paddr_nxt;
  logic                  r_pwrite, w_pwrite_nxt;
  logic [7:0]            r_pwdata, w_pwdata_nxt;
  logic [7:0]            r_tx_data, w_tx_data_nxt;
  logic [15:0]           r_cnt, w_cnt_nxt;
  logic                  r_overrun, w_overrun_nxt;
  logic [16:0]           w_cnt_inc;

  // 17-bit increment so the saturating compare cannot wrap at TIMEOUT_CYCLES = 65535
  assign w_cnt_inc = {1'b0, r_cnt} + 17'd1;

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      r_state   <= StIdle;
      r_paddr   <= '0;
      r_pwrite  <= 1'b0;
      r_pwdata  <= 8'h00;
      r_tx_data <= 8'h00;
      r_cnt     <= 16'h0000;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_paddr   <= w_paddr_nxt;
      r_pwrite  <= w_pwrite_nxt;
      r_pwdata  <= w_pwdata_nxt;
      r_tx_data <= w_tx_data_nxt;
      r_cnt     <= w_cnt_nxt;
      r_overrun <= w_overrun_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_paddr_nxt   = r_paddr;
    w_pwrite_nxt  = r_pwrite;
    w_pwdata_nxt  = r_pwdata;
    w_tx_data_nxt = r_tx_data;
    w_cnt_nxt     = r_cnt;
    w_overrun_nxt = r_overrun;

    unique case (r_state)
      StIdle: begin
        if (rx_valid) begin
          if (rx_data == CmdWrite || rx_data == CmdRead) begin
            w_pwrite_nxt = (rx_data == CmdWrite);
            w_state_nxt  = StGetAddr;
          end else begin
            w_tx_data_nxt = NAK_BYTE;
            w_state_nxt   = StResp;
          end
        end
      end
      StGetAddr: begin
        if (rx_valid) begin
          w_paddr_nxt = rx_data[ADDR_WIDTH-1:0];
          w_state_nxt = r_pwrite ? StGetData : StSetup;
        end
      end
      StGetData: begin
        if (rx_valid) begin
          w_pwdata_nxt = rx_data;
          w_state_nxt  = StSetup;
        end
      end
      StSetup: begin
        w_cnt_nxt   = 16'h0000;
        w_state_nxt = StAccess;
      end
      StAccess: begin
        if (PREADY) begin
          if (PSLVERR)       w_tx_data_nxt = NAK_BYTE;
          else if (r_pwrite) w_tx_data_nxt = ACK_BYTE;
          else               w_tx_data_nxt = PRDATA;
          w_state_nxt = StResp;
        end else if (w_cnt_inc >= TimeoutLimit) begin
          w_tx_data_nxt = NAK_BYTE;
          w_state_nxt   = StResp;
        end else begin
          w_cnt_nxt = w_cnt_inc[15:0];
        end
      end
      StResp: begin
        if (tx_ready) w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase

    // Bytes arriving while a transfer or response is in flight are lost
    if (rx_valid && (r_state == StSetup || r_state == StAccess || r_state == StResp)) begin
      w_overrun_nxt = 1'b1;
    end
  end

  assign PSEL     = (r_state == StSetup) || (r_state == StAccess);
  assign PENABLE  = (r_state == StAccess);
  assign tx_valid = (r_state == StResp);
  assign busy     = (r_state != StIdle);
  assign tx_data  = r_tx_data;
  assign PADDR    = r_paddr;
  assign PWRITE   = r_pwrite;
  assign PWDATA   = r_pwdata;
  assign overrun  = r_overrun;

endmodule
